// File: rtl/conv_window_ctrl.sv
// ============================================================================
// Module  : conv_window_ctrl
// Brief   : Raster sequencer and kernel-select owner for a 3x3 streaming conv.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_window_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int KSEL_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      x_valid,
  input  logic                      y_ready,
  output logic                      x_ready,
  output logic                      shift_en,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      window_valid,
  output logic                      sof,
  output logic                      eof,
  input  logic                      kernel_req,
  input  logic [KSEL_W-1:0]         kernel_req_sel,
  output logic [KSEL_W-1:0]         kernel_sel,
  output logic                      kernel_ack,
  output logic [1:0]                state
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [COL_W-1:0] c_col_last = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
  localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_SWAP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic                r_window_valid;
  logic                r_sof;
  logic                r_eof;
  logic [KSEL_W-1:0]   r_kernel_sel;
  logic                r_kernel_ack;
  logic [KSEL_W-1:0]   r_pending_sel;
  logic                r_pending;

  logic                w_last_col;
  logic                w_last_pix;
  logic                w_first_pix;
  logic                w_win_in;
  logic                w_swap_due;

  assign x_ready     = y_ready && (r_state != ST_SWAP);
  assign shift_en    = x_valid && x_ready;

  assign w_last_col  = (r_col == c_col_last);
  assign w_last_pix  = w_last_col && (r_row == c_row_last);
  assign w_first_pix = (r_col == '0) && (r_row == '0);
  assign w_win_in    = (r_row >= c_row_two) && (r_col >= c_col_two);
  // A request arriving with the last pixel still earns the swap.
  assign w_swap_due  = r_pending || kernel_req;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (shift_en) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (shift_en) begin
          if (w_last_pix)
            w_state_nxt = w_swap_due ? ST_SWAP : ST_FILL;
          else if ((r_row == c_row_two) && (r_col == c_col_two))
            w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (shift_en && w_last_pix)
          w_state_nxt = w_swap_due ? ST_SWAP : ST_FILL;
      end
      ST_SWAP: begin
        w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_col          <= '0;
      r_row          <= '0;
      r_window_valid <= 1'b0;
      r_sof          <= 1'b0;
      r_eof          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sof   <= shift_en && w_first_pix;
      r_eof   <= shift_en && w_last_pix;
      if (shift_en) begin
        r_window_valid <= w_win_in;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // In IDLE a request takes effect at once; otherwise it waits for SWAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernel_sel  <= '0;
      r_kernel_ack  <= 1'b0;
      r_pending_sel <= '0;
      r_pending     <= 1'b0;
    end else begin
      r_kernel_ack <= 1'b0;
      if (r_state == ST_IDLE && kernel_req) begin
        r_kernel_sel <= kernel_req_sel;
        r_kernel_ack <= 1'b1;
      end else if (r_state == ST_SWAP) begin
        r_kernel_sel <= r_pending_sel;
        r_kernel_ack <= 1'b1;
      end

      if (kernel_req && r_state != ST_IDLE) begin
        r_pending_sel <= kernel_req_sel;
        r_pending     <= 1'b1;
      end else if (r_state == ST_SWAP) begin
        r_pending     <= 1'b0;
      end
    end
  end

  assign col          = r_col;
  assign row          = r_row;
  assign window_valid = r_window_valid;
  assign sof          = r_sof;
  assign eof          = r_eof;
  assign kernel_sel   = r_kernel_sel;
  assign kernel_ack   = r_kernel_ack;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
// ============================================================================
// Module  : tb_conv_window_ctrl
// Brief   : Directed self-checking bench for conv_window_ctrl (8x4 frame).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_window_ctrl;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int KSEL_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              x_valid = 1'b0;
  logic              y_ready = 1'b0;
  logic              kernel_req = 1'b0;
  logic [KSEL_W-1:0] kernel_req_sel = '0;
  logic              x_ready;
  logic              shift_en;
  logic [2:0]        col;
  logic [1:0]        row;
  logic              window_valid;
  logic              sof;
  logic              eof;
  logic [KSEL_W-1:0] kernel_sel;
  logic              kernel_ack;
  logic [1:0]        state;

  int n_cmp = 0;
  int n_err = 0;

  conv_window_ctrl #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .KSEL_W(KSEL_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .x_valid       (x_valid),
    .y_ready       (y_ready),
    .x_ready       (x_ready),
    .shift_en      (shift_en),
    .col           (col),
    .row           (row),
    .window_valid  (window_valid),
    .sof           (sof),
    .eof           (eof),
    .kernel_req    (kernel_req),
    .kernel_req_sel(kernel_req_sel),
    .kernel_sel    (kernel_sel),
    .kernel_ack    (kernel_ack),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; x_valid = 1'b0; y_ready = 1'b1; kernel_req = 1'b0;
    #2;
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (col !== 3'd0 || row !== 2'd0) begin n_err++; $display("FAIL reset_pos: got r%0d c%0d want r0 c0", row, col); end
    n_cmp++; if ({window_valid, sof, eof, kernel_ack} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {window_valid, sof, eof, kernel_ack}); end
    n_cmp++; if (kernel_sel !== 2'd0) begin n_err++; $display("FAIL reset_ksel: got %0d want 0", kernel_sel); end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_kernel_idle;
    kernel_req = 1'b1; kernel_req_sel = 2'd2;
    tick;
    kernel_req = 1'b0;
    n_cmp++; if (kernel_sel !== 2'd2) begin n_err++; $display("FAIL idle_ksel: got %0d want 2", kernel_sel); end
    n_cmp++; if (kernel_ack !== 1'b1) begin n_err++; $display("FAIL idle_ack: got %b want 1", kernel_ack); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_state: got %0d want 0", state); end
    tick;
    n_cmp++; if (kernel_ack !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL idle_after: got ack %b state %0d want ack 0 state 0", kernel_ack, state); end
  endtask

  task automatic test_frame;
    int wv_cnt;
    logic [2:0] ec;
    logic [1:0] er;
    logic ewv;
    wv_cnt = 0;
    x_valid = 1'b1; y_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      ec = 3'(k % 8); er = 2'(k / 8);
      ewv = (er >= 2'd2) && (ec >= 3'd2);
      #1;
      n_cmp++; if (col !== ec || row !== er || shift_en !== 1'b1) begin n_err++; $display("FAIL frame_pos[%0d]: got r%0d c%0d se%b want r%0d c%0d se1", k, row, col, shift_en, er, ec); end
      tick;
      n_cmp++; if (sof !== (k == 0) || eof !== (k == 31)) begin n_err++; $display("FAIL frame_sof_eof[%0d]: got %b%b want %b%b", k, sof, eof, k == 0, k == 31); end
      n_cmp++; if (window_valid !== ewv) begin n_err++; $display("FAIL frame_wv[%0d]: got %b want %b", k, window_valid, ewv); end
      if (window_valid === 1'b1) wv_cnt++;
      if (k == 18) begin
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL frame_run: got %0d want 2", state); end
      end
    end
    x_valid = 1'b0;
    n_cmp++; if (wv_cnt != 12) begin n_err++; $display("FAIL frame_wv_count: got %0d want 12", wv_cnt); end
    n_cmp++; if (state !== 2'd1 || col !== 3'd0 || row !== 2'd0) begin n_err++; $display("FAIL frame_end: got st%0d r%0d c%0d want st1 r0 c0", state, row, col); end
    tick;
    n_cmp++; if (eof !== 1'b0) begin n_err++; $display("FAIL frame_eof_pulse: got %b want 0", eof); end
  endtask

  task automatic test_kernel_midframe;
    int acks;
    int ksel_bad;
    acks = 0; ksel_bad = 0;
    x_valid = 1'b1; y_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      kernel_req = (k == 9) || (k == 19);
      kernel_req_sel = (k == 9) ? 2'd1 : 2'd3;
      tick;
      kernel_req = 1'b0;
      if (kernel_ack === 1'b1) acks++;
      if (kernel_sel !== 2'd2) ksel_bad++;
    end
    n_cmp++; if (ksel_bad != 0 || acks != 0) begin n_err++; $display("FAIL mid_hold: got %0d ksel changes %0d acks want 0 0", ksel_bad, acks); end
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL mid_swap_state: got %0d want 3", state); end
    #1;
    n_cmp++; if (x_ready !== 1'b0 || shift_en !== 1'b0) begin n_err++; $display("FAIL mid_swap_ready: got xr%b se%b want 0 0", x_ready, shift_en); end
    tick;
    x_valid = 1'b0;
    n_cmp++; if (state !== 2'd1 || kernel_sel !== 2'd3 || kernel_ack !== 1'b1) begin n_err++; $display("FAIL mid_apply: got st%0d ksel%0d ack%b want st1 ksel3 ack1", state, kernel_sel, kernel_ack); end
    n_cmp++; if (col !== 3'd0 || row !== 2'd0) begin n_err++; $display("FAIL mid_no_advance: got r%0d c%0d want r0 c0", row, col); end
    tick;
    n_cmp++; if (kernel_ack !== 1'b0 || state !== 2'd1) begin n_err++; $display("FAIL mid_single_ack: got ack%b st%0d want ack0 st1", kernel_ack, state); end
  endtask

  task automatic test_kernel_last;
    x_valid = 1'b1; y_ready = 1'b1;
    repeat (31) tick;
    kernel_req = 1'b1; kernel_req_sel = 2'd1;
    tick;
    kernel_req = 1'b0; x_valid = 1'b0;
    n_cmp++; if (state !== 2'd3 || eof !== 1'b1 || kernel_sel !== 2'd3) begin n_err++; $display("FAIL last_swap: got st%0d eof%b ksel%0d want st3 eof1 ksel3", state, eof, kernel_sel); end
    tick;
    n_cmp++; if (state !== 2'd1 || kernel_sel !== 2'd1 || kernel_ack !== 1'b1) begin n_err++; $display("FAIL last_apply: got st%0d ksel%0d ack%b want st1 ksel1 ack1", state, kernel_sel, kernel_ack); end
  endtask

  task automatic test_stall;
    logic [2:0] ec;
    logic [1:0] er;
    x_valid = 1'b1; y_ready = 1'b1;
    repeat (20) tick;
    y_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_cmp++; if (x_ready !== 1'b0 || shift_en !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got xr%b se%b want 0 0", s, x_ready, shift_en); end
      tick;
      n_cmp++; if (col !== 3'd4 || row !== 2'd2 || window_valid !== 1'b1 || state !== 2'd2) begin n_err++; $display("FAIL stall_hold[%0d]: got r%0d c%0d wv%b st%0d want r2 c4 wv1 st2", s, row, col, window_valid, state); end
    end
    y_ready = 1'b1;
    for (int k = 20; k < 32; k++) begin
      ec = 3'(k % 8); er = 2'(k / 8);
      #1;
      n_cmp++; if (col !== ec || row !== er) begin n_err++; $display("FAIL stall_resume_pos[%0d]: got r%0d c%0d want r%0d c%0d", k, row, col, er, ec); end
      tick;
      n_cmp++; if (window_valid !== (ec >= 3'd2) || eof !== (k == 31)) begin n_err++; $display("FAIL stall_resume_out[%0d]: got wv%b eof%b want wv%b eof%b", k, window_valid, eof, ec >= 3'd2, k == 31); end
    end
    x_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    x_valid = 1'b1; y_ready = 1'b1;
    repeat (13) tick;
    x_valid = 1'b0;
    n_cmp++; if (col !== 3'd5 || row !== 2'd1 || kernel_sel !== 2'd1) begin n_err++; $display("FAIL areset_pre: got r%0d c%0d ksel%0d want r1 c5 ksel1", row, col, kernel_sel); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || col !== 3'd0 || row !== 2'd0 || kernel_sel !== 2'd0) begin n_err++; $display("FAIL areset_now: got st%0d r%0d c%0d ksel%0d want all 0", state, row, col, kernel_sel); end
    #2;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (state !== 2'd0 || sof !== 1'b0) begin n_err++; $display("FAIL areset_idle: got st%0d sof%b want st0 sof0", state, sof); end
    x_valid = 1'b1;
    tick;
    x_valid = 1'b0;
    n_cmp++; if (sof !== 1'b1 || state !== 2'd1 || col !== 3'd1 || row !== 2'd0) begin n_err++; $display("FAIL areset_sof: got sof%b st%0d r%0d c%0d want sof1 st1 r0 c1", sof, state, row, col); end
  endtask

  initial begin
    test_reset();
    test_kernel_idle();
    test_frame();
    test_kernel_midframe();
    test_kernel_last();
    test_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
